math_multiplier_booth_radix_4_sequential: RTL

Iterative signed N×N multiplier that consumes radix-4 Booth partial products, one per clock, and accumulates the 2N-bit product. It recodes the latched multiplier into 3-bit Booth groups and generates each partial product (0, ±M, ±2M) internally. It adds those partial products at their 2i weights. It sits in the common math library as the area-lean alternative to the combinational Booth array, behind a valid/ready handshake on both sides.

---
 rtl/math_booth_pkg.sv | 20 ++
 rtl/math_multiplier_booth_radix_4_pp_gen.sv | 36 +++
 rtl/math_multiplier_booth_radix_4_sequential.sv | 102 ++++++++++
 3 files changed

// File: rtl/math_booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM state encoding and Booth group codes.
package math_booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } booth_state_t;

  // Booth group {q[2i+1], q[2i], q[2i-1]}; two codes each select 0, +M and -M
  localparam logic [2:0] BOOTH_ZERO     = 3'b000;
  localparam logic [2:0] BOOTH_P1       = 3'b001;
  localparam logic [2:0] BOOTH_P1_ALT   = 3'b010;
  localparam logic [2:0] BOOTH_P2       = 3'b011;
  localparam logic [2:0] BOOTH_M2       = 3'b100;
  localparam logic [2:0] BOOTH_M1       = 3'b101;
  localparam logic [2:0] BOOTH_M1_ALT   = 3'b110;
  localparam logic [2:0] BOOTH_ZERO_ALT = 3'b111;

endpackage

// File: rtl/math_multiplier_booth_radix_4_pp_gen.sv
// Combinational radix-4 Booth partial-product generator: 3-bit group and N-bit M to an (N+1)-bit
// partial product plus its true sign bit.
module math_multiplier_booth_radix_4_pp_gen
  import math_booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2:0]   group,
  input  logic [N-1:0] m,
  output logic [N:0]   pp,
  output logic         pp_sign
);

  logic [N+1:0] m1_ext;
  logic [N+1:0] m2_ext;
  logic [N+1:0] exact;

  assign m1_ext = {{2{m[N-1]}}, m};
  assign m2_ext = {m[N-1], m, 1'b0};

  always_comb begin
    exact = '0;
    case (group)
      BOOTH_P1, BOOTH_P1_ALT: exact = m1_ext;
      BOOTH_P2:               exact = m2_ext;
      BOOTH_M2:               exact = -m2_ext;
      BOOTH_M1, BOOTH_M1_ALT: exact = -m1_ext;
      default:                exact = '0;
    endcase
  end

  // -2M of the most negative M is +2^N, which overflows pp; pp_sign keeps the real sign for extension
  assign pp      = exact[N:0];
  assign pp_sign = exact[N+1];

endmodule

// File: rtl/math_multiplier_booth_radix_4_sequential.sv
// Sequential signed NxN radix-4 Booth multiplier, one partial product per clock, valid/ready on both sides.
// Optional MATH_BOOTH_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are pure sign.
module math_multiplier_booth_radix_4_sequential
  import math_booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [N-1:0]   i_multiplicand,
  input  logic [N-1:0]   i_multiplier,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [2*N-1:0] o_product,
  output logic           o_busy
);

  localparam int W2 = 2 * N;
  localparam int IW = $clog2(N / 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(N / 2 - 1);

  booth_state_t  state_reg, state_next;
  logic [N-1:0]  m_reg;
  logic [N:0]    q_reg;
  logic [W2-1:0] acc_reg;
  logic [W2-1:0] product_reg;
  logic [IW-1:0] idx_reg;

  logic [N:0]    pp;
  logic          pp_sign;
  logic [W2-1:0] pp_ext;
  logic [W2-1:0] acc_next;
  logic          calc_done;

  // q_reg is {Q, 1'b0} shifted right by two per group, so bits [2:0] are always the current group
  math_multiplier_booth_radix_4_pp_gen #(.N(N)) u_pp_gen (
    .group   (q_reg[2:0]),
    .m       (m_reg),
    .pp      (pp),
    .pp_sign (pp_sign)
  );

  assign pp_ext   = {{(N-1){pp_sign}}, pp};
  assign acc_next = acc_reg + (pp_ext << {idx_reg, 1'b0});

`ifdef MATH_BOOTH_EARLY_TERM_EN
  // q_reg[N:2] holds Q[N-1:2i+1] padded with sign copies; uniform bits mean only 0 groups remain
  logic [N-2:0] q_rest;
  assign q_rest    = q_reg[N:2];
  assign calc_done = (idx_reg == LAST_IDX) || (&q_rest) || ~(|q_rest);
`else
  assign calc_done = (idx_reg == LAST_IDX);
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (i_valid)   state_next = ST_CALC;
      ST_CALC: if (calc_done) state_next = ST_DONE;
      ST_DONE: if (i_ready)   state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      m_reg       <= '0;
      q_reg       <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
      idx_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (i_valid) begin
            m_reg   <= i_multiplicand;
            q_reg   <= {i_multiplier, 1'b0};
            acc_reg <= '0;
            idx_reg <= '0;
          end
        end
        ST_CALC: begin
          acc_reg <= acc_next;
          q_reg   <= {{2{q_reg[N]}}, q_reg[N:2]};
          idx_reg <= idx_reg + IW'(1);
          if (calc_done) product_reg <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign o_ready   = (state_reg == ST_IDLE);
  assign o_busy    = (state_reg == ST_CALC);
  assign o_valid   = (state_reg == ST_DONE);
  assign o_product = product_reg;

endmodule
